// File: rtl/alu_pkg.sv
// Shared types and defaults for the sliced adder: FSM state, default geometry,
// and the slice-index width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // Slice counter needs at least one bit even when there is a single slice.
    function automatic int idx_width(input int nslice);
        int w;
        w = $clog2(nslice);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder with active-low carry in and carry out.
module adder_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             nc_i,
    output logic [SLICE-1:0] s_o,
    output logic             nc_o
);

    // Ripple the true-polarity carry through the slice, inverting only at the edges.
    always_comb begin
        logic c;
        c   = ~nc_i;
        s_o = '0;
        for (int i = 0; i < SLICE; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        nc_o = ~c;
    end

endmodule

// File: rtl/sliced_adder.sv
// Multi-cycle adder/subtractor computing one SLICE-bit slice per clock, LSB first.
// Define SLICED_ADDER_FLAGS_EN to add registered Z/N/V flag outputs.
module sliced_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             nCin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] S,
`ifdef SLICED_ADDER_FLAGS_EN
    output logic             nCout,
    output logic             Z,
    output logic             N,
    output logic             V
`else
    output logic             nCout
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = idx_width(NSLICE);

    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_cfg
        $fatal(1, "sliced_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             nc_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] s_q;
    logic             ncout_q;
    logic             valid_q;
    logic             ready_q;

    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic [SLICE-1:0] sum_s;
    logic             nco_s;
    logic [WIDTH-1:0] acc_d;
    logic             last_s;

    // Select the active slice and merge its sum into the running accumulator.
    always_comb begin
        a_sl_s = opa_q[int'(k_q)*SLICE +: SLICE];
        b_sl_s = opb_q[int'(k_q)*SLICE +: SLICE];
        acc_d  = acc_q;
        acc_d[int'(k_q)*SLICE +: SLICE] = sum_s;
        last_s = (k_q == KW'(NSLICE - 1));
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i  (a_sl_s),
        .b_i  (b_sl_s),
        .nc_i (nc_q),
        .s_o  (sum_s),
        .nc_o (nco_s)
    );

`ifdef SLICED_ADDER_FLAGS_EN
    logic z_q;
    logic n_q;
    logic v_q;
    logic v_s;

    // Signed overflow: operands agree in sign but the result MSB does not.
    always_comb begin
        v_s = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum_s[SLICE-1] != opa_q[WIDTH-1]);
    end

    // Flags commit only on the completion edge, alongside S.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if ((state_q == RUN) && last_s) begin
            z_q <= (acc_d == '0);
            n_q <= acc_d[WIDTH-1];
            v_q <= v_s;
        end else begin
            z_q <= z_q;
            n_q <= n_q;
            v_q <= v_q;
        end
    end

    assign Z = z_q;
    assign N = n_q;
    assign V = v_q;
`endif

    // Control FSM with operand capture, slice stepping and result commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            nc_q    <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            ncout_q <= 1'b1;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        opa_q   <= A;
                        opb_q   <= sub ? ~B : B;
                        nc_q    <= nCin;
                        k_q     <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    nc_q  <= nco_s;
                    if (last_s) begin
                        k_q     <= '0;
                        s_q     <= acc_d;
                        ncout_q <= nco_s;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                    k_q     <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign valid = valid_q;
    assign S     = s_q;
    assign nCout = ncout_q;

endmodule

// File: tb/tb_sliced_adder.sv
// Scoreboard bench for sliced_adder at 32/8, 8/8 and 16/4; flag outputs are
// checked when SLICED_ADDER_FLAGS_EN is defined.
module tb_sliced_adder;

    typedef struct {
        longint unsigned s;
        bit              nc;
        bit              z;
        bit              n;
        bit              v;
        int              at;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ndone  = 0;

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Reference: integer arithmetic on the full-width values, signed range test for V.
    function automatic exp_t ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                       input bit sub, input bit ncin);
        exp_t            e;
        longint unsigned mask;
        longint unsigned half;
        longint unsigned bx;
        longint unsigned cin;
        longint unsigned full;
        longint          sa;
        longint          sb;
        longint          tot;
        mask = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        bx   = sub ? (~b & mask) : (b & mask);
        cin  = ncin ? 64'd0 : 64'd1;
        full = (a & mask) + bx + cin;
        sa   = ((a & mask) >= half) ? longint'(a & mask) - longint'(mask + 64'd1) : longint'(a & mask);
        sb   = (bx >= half) ? longint'(bx) - longint'(mask + 64'd1) : longint'(bx);
        tot  = sa + sb + longint'(cin);
        e.s  = full & mask;
        e.nc = ((full >> w) & 64'd1) == 64'd0;
        e.z  = (e.s == 64'd0);
        e.n  = (e.s & half) != 64'd0;
        e.v  = (tot > longint'(half) - 64'sd1) || (tot < -longint'(half));
        e.at = 0;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 32 : ((g == 1) ? 8 : 16);
        localparam int SL = (g == 2) ? 4 : 8;
        localparam int NS = W / SL;

        logic         rst_n;
        logic         start;
        logic         sub;
        logic         nCin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ready;
        logic         valid;
        logic [W-1:0] s;
        logic         nCout;
`ifdef SLICED_ADDER_FLAGS_EN
        logic         z;
        logic         n;
        logic         v;
`endif
        exp_t         q[$];
        int           cyc = 0;

        sliced_adder #(
            .WIDTH (W),
            .SLICE (SL)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .sub   (sub),
            .nCin  (nCin),
            .A     (a),
            .B     (b),
            .ready (ready),
            .valid (valid),
            .S     (s),
`ifdef SLICED_ADDER_FLAGS_EN
            .nCout (nCout),
            .Z     (z),
            .N     (n),
            .V     (v)
`else
            .nCout (nCout)
`endif
        );

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        task automatic c(input string nm, input longint unsigned act, input longint unsigned expv);
            chk($sformatf("w%0d_s%0d_%s", W, SL, nm), act, expv);
        endtask

        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub, input logic tnc);
            exp_t e;
            c("ready_at_issue", 64'(ready), 64'd1);
            a = ta; b = tb_v; sub = tsub; nCin = tnc; start = 1'b1;
            e    = ref_model(W, 64'(ta), 64'(tb_v), tsub, tnc);
            e.at = cyc + 1 + NS;
            q.push_back(e);
        endtask

        // Issue, then scribble on the inputs (including start) while busy.
        task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub, input logic tnc);
            issue(ta, tb_v, tsub, tnc);
            for (int i = 0; i < NS; i++) begin
                @(negedge clk);
                c("ready_busy", 64'(ready), 64'd0);
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            c("ready_done", 64'(ready), 64'd1);
        endtask

        // Monitor: every valid pulse must match the oldest outstanding expectation.
        initial forever begin
            exp_t e;
            @(negedge clk);
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    c("unexpected_valid", 64'(valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    c("S", 64'(s), e.s);
                    c("nCout", 64'(nCout), 64'(e.nc));
                    c("latency", 64'(cyc), 64'(e.at));
`ifdef SLICED_ADDER_FLAGS_EN
                    c("Z", 64'(z), 64'(e.z));
                    c("N", 64'(n), 64'(e.n));
                    c("V", 64'(v), 64'(e.v));
`endif
                end
            end
        end

        initial begin
            rst_n = 1'b0; start = 1'b0; sub = 1'b0; nCin = 1'b1; a = '0; b = '0;
            repeat (2) @(negedge clk);
            c("rst_S", 64'(s), 64'd0);
            c("rst_nCout", 64'(nCout), 64'd1);
            c("rst_valid", 64'(valid), 64'd0);
            c("rst_ready", 64'(ready), 64'd1);
`ifdef SLICED_ADDER_FLAGS_EN
            c("rst_flags", 64'({z, n, v}), 64'd0);
`endif
            rst_n = 1'b1;
            @(negedge clk);

            op(W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 1'b1);
            @(negedge clk);
            op(W'(32'd5), W'(32'd7), 1'b1, 1'b0);
            @(negedge clk);
            op('1, W'(32'd1), 1'b0, 1'b1);
            @(negedge clk);
            op({1'b0, {(W-1){1'b1}}}, W'(32'd1), 1'b0, 1'b1);

            // Back-to-back through DONE: op leaves us in the DONE cycle.
            op(W'($urandom), W'($urandom), 1'b0, 1'b1);
            op(W'($urandom), W'($urandom), 1'b1, 1'b0);
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);

            // Abort an operation with reset on its second RUN edge (only edge when NS=1).
            issue(W'(32'h1234_5678), W'(32'h0F0F_0F0F), 1'b0, 1'b1);
            void'(q.pop_back());
            repeat ((NS >= 2) ? 2 : 1) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst_n = 1'b0;
            @(negedge clk);
            c("abort_S", 64'(s), 64'd0);
            c("abort_nCout", 64'(nCout), 64'd1);
            c("abort_valid", 64'(valid), 64'd0);
            c("abort_ready", 64'(ready), 64'd1);
            rst_n = 1'b1;
            @(negedge clk);

            for (int i = 0; i < 30; i++) begin
                op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                end
            end

            repeat (NS + 4) @(negedge clk);
            c("pending_at_end", 64'(q.size()), 64'd0);
            ndone++;
        end
    end

    initial begin
        for (int t = 0; (t < 50000) && (ndone < 3); t++) begin
            @(posedge clk);
        end
        if (ndone < 3) begin
            checks++;
            errors++;
            $display("FAIL timeout: finished=%0d required=3", ndone);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
